// File: rtl/lfsr_checker.sv
// lfsr_checker: self-seeding receive-side checker for the 4-bit LFSR
// pattern (x[n] = x[n-4] ^ x[n-2]); reports lock, errors and sync loss.
module lfsr_checker #(
    parameter int LOSS_THRESH = 3,
    parameter int ERR_CNT_W   = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clear_i,
    input  logic                 bit_i,
    input  logic                 bit_valid_i,
    output logic                 locked_o,
    output logic                 err_o,
    output logic                 sync_loss_o,
    output logic [ERR_CNT_W-1:0] err_cnt_o
);

    typedef enum logic {
        ST_LOAD,
        ST_LOCKED
    } state_t;

    localparam logic [3:0] THRESH = 4'(LOSS_THRESH);
    localparam logic [ERR_CNT_W-1:0] CNT_ONE = {{(ERR_CNT_W-1){1'b0}}, 1'b1};

    state_t                 state_q, state_d;
    logic [3:0]             shadow_q, shadow_d;
    logic [2:0]             load_cnt_q, load_cnt_d;
    logic [3:0]             miss_q, miss_d;
    logic [ERR_CNT_W-1:0]   cnt_q, cnt_d;
    logic                   locked_q, locked_d;
    logic                   err_q, err_d;
    logic                   sl_q, sl_d;
    logic                   pred;
    logic [3:0]             miss_inc;

    assign pred     = shadow_q[3] ^ shadow_q[1];
    assign miss_inc = miss_q + 4'd1;

    // Next-state: seed from four received bits, then track on predictions
    always_comb begin
        state_d    = state_q;
        shadow_d   = shadow_q;
        load_cnt_d = load_cnt_q;
        miss_d     = miss_q;
        cnt_d      = cnt_q;
        err_d      = 1'b0;
        sl_d       = 1'b0;
        if (bit_valid_i) begin
            unique case (state_q)
                ST_LOAD: begin
                    shadow_d = {shadow_q[2:0], bit_i};
                    if (load_cnt_q == 3'd3) begin
                        load_cnt_d = 3'd0;
                        // An all-zero seed would lock onto a dead line
                        if (shadow_d != 4'd0) begin
                            state_d = ST_LOCKED;
                            miss_d  = 4'd0;
                        end
                    end else begin
                        load_cnt_d = load_cnt_q + 3'd1;
                    end
                end
                ST_LOCKED: begin
                    // Shift the prediction so a bad bit cannot derail tracking
                    shadow_d = {shadow_q[2:0], pred};
                    if (bit_i == pred) begin
                        miss_d = 4'd0;
                    end else begin
                        err_d = 1'b1;
                        if (cnt_q != {ERR_CNT_W{1'b1}}) begin
                            cnt_d = cnt_q + CNT_ONE;
                        end
                        miss_d = miss_inc;
                        if (miss_inc == THRESH) begin
                            state_d    = ST_LOAD;
                            load_cnt_d = 3'd0;
                            miss_d     = 4'd0;
                            sl_d       = 1'b1;
                        end
                    end
                end
                default: state_d = ST_LOAD;
            endcase
        end
        if (clear_i) begin
            cnt_d = '0;
        end
        locked_d = (state_d == ST_LOCKED);
    end

    // State and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_LOAD;
            shadow_q   <= 4'd0;
            load_cnt_q <= 3'd0;
            miss_q     <= 4'd0;
            cnt_q      <= '0;
            locked_q   <= 1'b0;
            err_q      <= 1'b0;
            sl_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            shadow_q   <= shadow_d;
            load_cnt_q <= load_cnt_d;
            miss_q     <= miss_d;
            cnt_q      <= cnt_d;
            locked_q   <= locked_d;
            err_q      <= err_d;
            sl_q       <= sl_d;
        end
    end

    assign locked_o    = locked_q;
    assign err_o       = err_q;
    assign sync_loss_o = sl_q;
    assign err_cnt_o   = cnt_q;

endmodule

// File: tb/tb_lfsr_checker.sv
// tb_lfsr_checker: randomized scoreboard bench for lfsr_checker
// with a sequence-level reference model.
module tb_lfsr_checker;

    localparam int THR     = 3;
    localparam int CW      = 4;
    localparam int CNT_MAX = (1 << CW) - 1;

    typedef struct packed {
        logic          l;
        logic          e;
        logic          s;
        logic [CW-1:0] c;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          clear_i;
    logic          bit_i;
    logic          bit_valid_i;
    logic          locked_o;
    logic          err_o;
    logic          sync_loss_o;
    logic [CW-1:0] err_cnt_o;

    int checks = 0;
    int errors = 0;

    exp_t sbq[$];
    exp_t mon_e;

    // reference model state: collected seed bits, last four tracked bits
    bit m_locked;
    bit m_seed[$];
    bit m_hist[$];
    int m_miss;
    int m_cnt;

    bit pat[6] = '{1, 0, 1, 0, 0, 0};
    int pidx;

    lfsr_checker #(.LOSS_THRESH(THR), .ERR_CNT_W(CW)) dut (
        .clk        (clk),
        .reset      (reset),
        .clear_i    (clear_i),
        .bit_i      (bit_i),
        .bit_valid_i(bit_valid_i),
        .locked_o   (locked_o),
        .err_o      (err_o),
        .sync_loss_o(sync_loss_o),
        .err_cnt_o  (err_cnt_o)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    function automatic bit m_pred();
        return m_hist[0] ^ m_hist[2];
    endfunction

    task automatic model_reset();
        m_locked = 0;
        m_seed.delete();
        m_hist.delete();
        m_miss = 0;
        m_cnt  = 0;
    endtask

    task automatic model_step(input bit v, input bit b, input bit c,
                              output exp_t e);
        bit p;
        bit any1;
        e.e = 0;
        e.s = 0;
        if (v) begin
            if (!m_locked) begin
                m_seed.push_back(b);
                if (m_seed.size() == 4) begin
                    any1 = m_seed[0] | m_seed[1] | m_seed[2] | m_seed[3];
                    if (any1) begin
                        m_locked = 1;
                        m_hist   = m_seed;
                        m_miss   = 0;
                    end
                    m_seed.delete();
                end
            end else begin
                p = m_pred();
                m_hist.push_back(p);
                void'(m_hist.pop_front());
                if (b == p) begin
                    m_miss = 0;
                end else begin
                    e.e = 1;
                    if (m_cnt < CNT_MAX) m_cnt++;
                    m_miss++;
                    if (m_miss == THR) begin
                        e.s      = 1;
                        m_locked = 0;
                        m_miss   = 0;
                        m_seed.delete();
                    end
                end
            end
        end
        if (c) m_cnt = 0;
        e.l = m_locked;
        e.c = CW'(m_cnt);
    endtask

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    // driver: inputs change at posedge+2, one expectation per edge
    task automatic step(input bit v, input bit b, input bit c);
        exp_t e;
        bit_valid_i = v;
        bit_i       = b;
        clear_i     = c;
        model_step(v, b, c, e);
        sbq.push_back(e);
        @(posedge clk);
        #2;
    endtask

    task automatic clean(input int n, input bit gaps);
        for (int i = 0; i < n; i++) begin
            step(1'b1, pat[pidx % 6], 1'b0);
            pidx++;
            if (gaps) step(1'b0, 1'($urandom_range(1)), 1'b0);
        end
    endtask

    task automatic flip(input bit c);
        step(1'b1, ~pat[pidx % 6], c);
        pidx++;
    endtask

    task automatic async_reset();
        reset = 1'b1;
        #1;
        chk("rst_locked", int'(locked_o), 0);
        chk("rst_err", int'(err_o), 0);
        chk("rst_sync_loss", int'(sync_loss_o), 0);
        chk("rst_cnt", int'(err_cnt_o), 0);
        #1;
        reset = 1'b0;
        model_reset();
    endtask

    // monitor: pops and compares one expectation after each edge
    always @(posedge clk) begin
        #1;
        if (sbq.size() > 0) begin
            mon_e = sbq.pop_front();
            checks++;
            if ({locked_o, err_o, sync_loss_o, err_cnt_o} !== mon_e) begin
                errors++;
                $display("FAIL sb t=%0t got l=%b e=%b s=%b c=%0d exp l=%b e=%b s=%b c=%0d",
                         $time, locked_o, err_o, sync_loss_o, err_cnt_o,
                         mon_e.l, mon_e.e, mon_e.s, mon_e.c);
            end
        end
    end

    initial begin
        bit b;
        bit v;
        bit c;
        reset       = 1'b1;
        clear_i     = 1'b0;
        bit_i       = 1'b0;
        bit_valid_i = 1'b0;
        model_reset();
        pidx = 0;
        repeat (3) @(posedge clk);
        #2;
        chk("init_locked", int'(locked_o), 0);
        chk("init_cnt", int'(err_cnt_o), 0);
        reset = 1'b0;

        // clean lock over 64 bits
        clean(64, 1'b0);
        chk("clean_locked", int'(locked_o), 1);
        chk("clean_cnt", int'(err_cnt_o), 0);

        // single flip
        flip(1'b0);
        clean(20, 1'b0);
        chk("flip_cnt", int'(err_cnt_o), 1);
        chk("flip_locked", int'(locked_o), 1);

        // loss of sync, then relock
        for (int i = 0; i < THR; i++) begin
            step(1'b1, ~m_pred(), 1'b0);
            pidx++;
        end
        chk("loss_locked", int'(locked_o), 0);
        chk("loss_cnt", int'(err_cnt_o), 4);
        clean(12, 1'b0);
        chk("relock", int'(locked_o), 1);

        // async reset mid-lock
        async_reset();

        // zero seed, then gapped clean stream
        repeat (4) step(1'b1, 1'b0, 1'b0);
        chk("zero_locked", int'(locked_o), 0);
        pidx = 0;
        clean(30, 1'b1);
        chk("gap_locked", int'(locked_o), 1);
        chk("gap_cnt", int'(err_cnt_o), 0);

        // saturation, then clear together with an error
        for (int i = 0; i < 20; i++) begin
            flip(1'b0);
            clean(2, 1'b0);
        end
        chk("sat_cnt", int'(err_cnt_o), CNT_MAX);
        flip(1'b1);
        chk("clr_err", int'(err_o), 1);
        chk("clr_cnt", int'(err_cnt_o), 0);
        clean(6, 1'b0);

        // randomized traffic
        for (int i = 0; i < 1500; i++) begin
            v = ($urandom_range(3) != 0);
            c = ($urandom_range(40) == 0);
            if (m_locked) b = m_pred() ^ ($urandom_range(7) == 0);
            else          b = 1'($urandom_range(1));
            step(v, b, c);
            if ($urandom_range(400) == 0) async_reset();
        end

        @(posedge clk);
        #3;
        chk("sb_drained", sbq.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/lfsr_checker.md
# lfsr_checker

Serial pattern checker for the 4-bit LFSR pattern generator (feedback bit = state[3] ^ state[1], shifted into bit[0]). It sits on the receive side of a link or loopback path and takes one pattern bit per valid cycle. It self-seeds from the first four bits received, then predicts every following bit and flags mismatches. It reports lock status, per-bit error pulses, a saturating error count and loss-of-sync events.

## Interface
- LOSS_THRESH, default 3: consecutive mismatches in LOCKED that force re-seeding (legal range 1..15).
- ERR_CNT_W, default 16: width of the error counter.

- clk  in  1  single clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- clear_i  in  1  synchronous clear of err_cnt_o
- bit_i  in  1  received pattern bit (generator state bit[0] each cycle)
- bit_valid_i  in  1  bit_i is valid this cycle; when low, nothing changes except clear_i
- locked_o  out  1  checker is seeded and tracking
- err_o  out  1  one-cycle pulse: last valid bit mismatched prediction while locked
- sync_loss_o  out  1  one-cycle pulse: lock dropped due to LOSS_THRESH mismatches
- err_cnt_o  out  ERR_CNT_W  total mismatches since reset/clear, saturating

## Operation
- Internal registers: shadow[3:0], load_cnt (0..4), miss_cnt (0..LOSS_THRESH), state.
- The prediction for each valid bit in LOCKED is shadow[3] ^ shadow[1].
- State LOAD (reset state):
  - Each valid bit sets shadow <= {shadow[2:0], bit_i} and increments load_cnt.
  - When the 4th bit is loaded, check the new shadow value.
  - If it is nonzero, go to LOCKED and clear miss_cnt.
  - If it is 0000, stay in LOAD and reset load_cnt to 0. An all-zero seed is illegal because a stuck-at-0 line would track forever.
- State LOCKED:
  - Each valid bit sets shadow <= {shadow[2:0], prediction}. The predicted bit is shifted in, not bit_i, so a single bit error does not corrupt the tracking state.
  - If bit_i equals the prediction, set miss_cnt to 0.
  - If it mismatches:
    - Pulse err_o and increment err_cnt_o (saturating at all-ones).
    - Increment miss_cnt.
    - If miss_cnt reaches LOSS_THRESH, pulse sync_loss_o, return to LOAD and clear load_cnt and miss_cnt. That bit is counted as an error but is not used for seeding; seeding restarts with the next valid bit.
- Bits arriving in LOAD are never counted as errors.
- clear_i together with a counted error in the same cycle: the clear wins, so err_cnt_o becomes 0. err_o still pulses.
- The counter stays at all-ones once saturated until clear_i or reset.

## Timing
- All outputs are registered.
- Reset values: locked_o=0, err_o=0, sync_loss_o=0, err_cnt_o=0. Internally shadow=0000, load_cnt=0, miss_cnt=0, state=LOAD.
- Reset asserted mid-operation clears everything asynchronously. After release, the checker needs 4 fresh valid bits to seed.
- locked_o rises in the cycle after the edge that samples the 4th valid nonzero seed bit.
- The first compared bit is the 5th valid bit.
- Mismatch reporting: err_o and the err_cnt_o update are visible in the cycle after the edge that samples the offending bit.
- Loss of sync: sync_loss_o pulses and locked_o falls in the same cycle as the err_o pulse for the LOSS_THRESH-th consecutive mismatch.
- bit_valid_i gaps of any length are transparent: the prediction resumes with the next valid bit.

## Test plan
- **Clean lock.** Feed the generator stream after its reset (bit[0] sequence 1,0,1,0,0,0 repeating) with valid every cycle.
  - locked_o=1 the cycle after the 4th bit.
  - err_o never pulses over 60 bits; err_cnt_o=0.
- **Single flip.** Invert one bit after lock.
  - Exactly one err_o pulse; err_cnt_o=1.
  - locked_o stays 1 and no further errors follow.
- **Loss of sync.** With LOSS_THRESH=3, force bit_i to the complement of the prediction for 3 bits.
  - err_cnt_o=3, sync_loss_o pulses once and locked_o=0.
  - Resume the clean stream: relock after 4 bits.
- **Zero seed and gaps.**
  - Feed 0,0,0,0: locked_o stays 0 and err_cnt_o stays 0.
  - Then a clean stream with bit_valid_i toggling 1/0: locks and reports zero errors.
- **Saturation and clear.** With ERR_CNT_W=4, inject 20 errors spaced by good bits.
  - err_cnt_o holds at 15.
  - clear_i together with an error: next cycle err_cnt_o=0 and err_o=1.
- **Async reset mid-lock.** Pulse reset between clock edges.
  - locked_o, err_cnt_o and both pulse outputs go to 0 immediately.
